// File: rtl/ant_buf_pkg.sv
// Shared types and constants for the antenna ping-pong buffer write scheduler.
package ant_buf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    EVEN,
    WAIT_ODD,
    ODD,
    ODD_FILL,
    GAP
  } sched_state_t;

  localparam int RE_NUM_DEFAULT = 1584;
  localparam int IQ_WIDTH       = 32;

endpackage

// File: rtl/ant_buf_rr_arb.sv
// Combinational round-robin pick: lowest requesting index at or after the
// pointer, wrapping to the lowest requesting index overall.
module ant_buf_rr_arb #(
  parameter int NUM = 2,
  parameter int IW  = 1
) (
  input  logic [NUM-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [IW-1:0]  o_idx,
  output logic           o_found
);

  // wrap candidate from the first loop is overridden by any hit at/after the pointer
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int j = NUM - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        o_idx   = IW'(j);
        o_found = 1'b1;
      end
    end
    for (int j = NUM - 1; j >= 0; j--) begin
      if (i_req[j] && (IW'(j) >= i_ptr)) begin
        o_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ant_buf_wr_sched.sv
// Write-side scheduler for the antenna ping-pong symbol buffer. Grants one
// even/odd source pair at a time so the buffer always sees the even burst
// followed by the odd burst of the same pair.
// Optional macro ANT_BUF_SCHED_TIMEOUT_EN: WAIT_ODD timeout with zero-filled
// odd burst and sticky o_err; when undefined o_err is tied low.
//
// state    | meaning
// IDLE     | post-reset, moves to ARB
// ARB      | pick next pair with even request (blocked by afull)
// EVEN     | stream RE_NUM beats from even source
// WAIT_ODD | wait for odd source of the same pair
// ODD      | stream RE_NUM beats from odd source
// ODD_FILL | emit RE_NUM zero beats after odd timeout
// GAP      | forced idle cycles before next arbitration
module ant_buf_wr_sched
  import ant_buf_pkg::*;
#(
  parameter  int ANT        = 4,
  parameter  int NUM_PAIR   = 2,
  parameter  int RE_NUM     = RE_NUM_DEFAULT,
  parameter  int ADDR_WIDTH = 11,
  parameter  int GAP_CYC    = 4,
  parameter  int TIMEOUT    = 4096,
  localparam int PW         = (NUM_PAIR > 1) ? $clog2(NUM_PAIR) : 1,
  localparam int NSRC       = 2 * NUM_PAIR,
  localparam int DW         = ANT * IQ_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NSRC-1:0]            i_src_req,
  input  logic [NSRC-1:0][63:0]      i_src_info0,
  input  logic [NSRC-1:0][7:0]       i_src_info1,
  input  logic [NSRC-1:0][DW-1:0]    i_src_data,
  input  logic [NSRC-1:0]            i_src_vld,
  output logic [NSRC-1:0]            o_src_rdy,
  input  logic                       i_buf_afull,
  output logic [ADDR_WIDTH-1:0]      o_iq_addr,
  output logic [DW-1:0]              o_iq_data,
  output logic                       o_iq_vld,
  output logic                       o_iq_last,
  output logic [63:0]                o_info_0,
  output logic [7:0]                 o_info_1,
  output logic [PW-1:0]              o_grant_pair,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RE_NUM - 1);

  if (RE_NUM > 2 ** ADDR_WIDTH) begin : g_chk_re_num
    $error("RE_NUM does not fit in ADDR_WIDTH");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("TIMEOUT must be at least 1");
  end

  sched_state_t          state_q, state_d;
  logic [PW-1:0]         pair_q, pair_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  iq_vld_q, iq_vld_d;
  logic                  iq_last_q, iq_last_d;
  logic [ADDR_WIDTH-1:0] iq_addr_q, iq_addr_d;
  logic [DW-1:0]         iq_data_q, iq_data_d;
  logic [63:0]           info0_q, info0_d;
  logic [7:0]            info1_q, info1_d;
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]         to_q, to_d;
  logic                  err_q, err_d;
`endif

  logic [NUM_PAIR-1:0] even_req;
  logic [PW-1:0]       arb_idx;
  logic                arb_found;
  logic [PW:0]         even_sel, odd_sel, grant_sel;
  logic [NSRC-1:0]     src_rdy;
  logic                beat;
  logic [DW-1:0]       beat_data;
  logic [PW-1:0]       rr_next;

  // even-source requests feed the pair arbiter
  always_comb begin
    for (int p = 0; p < NUM_PAIR; p++) begin
      even_req[p] = i_src_req[2*p];
    end
  end

  ant_buf_rr_arb #(.NUM(NUM_PAIR), .IW(PW)) u_rr_arb (
    .i_req   (even_req),
    .i_ptr   (rr_ptr_q),
    .o_idx   (arb_idx),
    .o_found (arb_found)
  );

  assign even_sel  = {pair_q, 1'b0};
  assign odd_sel   = {pair_q, 1'b1};
  assign grant_sel = {arb_idx, 1'b0};
  assign rr_next   = (pair_q == PW'(NUM_PAIR - 1)) ? '0 : pair_q + PW'(1);

  // ready is a pure decode of state so it drops with reset immediately
  always_comb begin
    src_rdy = '0;
    if (state_q == EVEN)     src_rdy[even_sel] = 1'b1;
    else if (state_q == ODD) src_rdy[odd_sel]  = 1'b1;
  end

  // next-state, beat acceptance and output register inputs
  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    iq_vld_d  = 1'b0;
    iq_last_d = 1'b0;
    iq_addr_d = iq_addr_q;
    iq_data_d = iq_data_q;
    info0_d   = info0_q;
    info1_d   = info1_q;
    beat      = 1'b0;
    beat_data = '0;
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
    to_d      = to_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: state_d = ARB;
      ARB: begin
        if (!i_buf_afull && arb_found) begin
          pair_d  = arb_idx;
          info0_d = i_src_info0[grant_sel];
          info1_d = i_src_info1[grant_sel];
          cnt_d   = '0;
          state_d = EVEN;
        end
      end
      EVEN: begin
        if (i_src_vld[even_sel]) begin
          beat      = 1'b1;
          beat_data = i_src_data[even_sel];
          if (cnt_q == LAST_ADDR) begin
            state_d = WAIT_ODD;
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
            to_d    = TW'(TIMEOUT - 1);
`endif
          end
        end
      end
      WAIT_ODD: begin
        if (i_src_req[odd_sel]) begin
          info0_d = i_src_info0[odd_sel];
          info1_d = i_src_info1[odd_sel];
          cnt_d   = '0;
          state_d = ODD;
        end
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
        else if (to_q == '0) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ODD_FILL;
        end else begin
          to_d = to_q - TW'(1);
        end
`endif
      end
      ODD: begin
        if (i_src_vld[odd_sel]) begin
          beat      = 1'b1;
          beat_data = i_src_data[odd_sel];
          if (cnt_q == LAST_ADDR) begin
            state_d  = GAP;
            gap_d    = GW'(GAP_CYC);
            rr_ptr_d = rr_next;
          end
        end
      end
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
      ODD_FILL: begin
        beat = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d  = GAP;
          gap_d    = GW'(GAP_CYC);
          rr_ptr_d = rr_next;
        end
      end
`endif
      GAP: begin
        // a GAP_CYC of 0 still spends one cycle here
        if (gap_q <= GW'(1)) state_d = ARB;
        else                 gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (beat) begin
      iq_vld_d  = 1'b1;
      iq_addr_d = cnt_q;
      iq_data_d = beat_data;
      iq_last_d = (cnt_q == LAST_ADDR);
      cnt_d     = (cnt_q == LAST_ADDR) ? '0 : cnt_q + ADDR_WIDTH'(1);
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      iq_vld_q  <= 1'b0;
      iq_last_q <= 1'b0;
      iq_addr_q <= '0;
      iq_data_q <= '0;
      info0_q   <= '0;
      info1_q   <= '0;
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
      to_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      iq_vld_q  <= iq_vld_d;
      iq_last_q <= iq_last_d;
      iq_addr_q <= iq_addr_d;
      iq_data_q <= iq_data_d;
      info0_q   <= info0_d;
      info1_q   <= info1_d;
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
      to_q      <= to_d;
      err_q     <= err_d;
`endif
    end
  end

  assign o_src_rdy    = src_rdy;
  assign o_iq_vld     = iq_vld_q;
  assign o_iq_last    = iq_last_q;
  assign o_iq_addr    = iq_addr_q;
  assign o_iq_data    = iq_data_q;
  assign o_info_0     = info0_q;
  assign o_info_1     = info1_q;
  assign o_grant_pair = pair_q;
  assign o_busy       = (state_q != IDLE);
`ifdef ANT_BUF_SCHED_TIMEOUT_EN
  assign o_err        = err_q;
`else
  assign o_err        = 1'b0;
`endif

endmodule

// File: doc/ant_buf_wr_sched.md
Name: ant_buf_wr_sched

Overview:
- Write-side scheduler for the antenna ping-pong symbol buffer.
- Arbitrates NUM_PAIR antenna-pair sources; each pair has an even-antenna source and an odd-antenna source, each delivering one symbol burst of RE_NUM beats.
- Emits iq_addr/iq_data/iq_vld/iq_last/info so the buffer's even/odd toggle always receives the even burst and then the odd burst of the same pair.
- Sits between the per-lane FFT/decompress outputs and the buffer write port.

Parameters:
- ANT, 4, antennas per beat (32-bit IQ each).
- NUM_PAIR, 2, number of even/odd source pairs; sources indexed 2p (even) and 2p+1 (odd).
- RE_NUM, 1584, beats per symbol burst (132 PRB x 12).
- ADDR_WIDTH, 11, width of o_iq_addr.
- GAP_CYC, 4, idle cycles forced after each odd burst; 0 is legal.
- TIMEOUT, 4096, WAIT_ODD timeout in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_src_req  in  2*NUM_PAIR  source holds a complete symbol; level, sampled only in ARB/WAIT_ODD.
- i_src_info0  in  2*NUM_PAIR x 64  IQ header per source; stable while req is high.
- i_src_info1  in  2*NUM_PAIR x 8  FFT AGC per source.
- i_src_data  in  2*NUM_PAIR x ANT x 32  beat data.
- i_src_vld  in  2*NUM_PAIR  beat valid.
- o_src_rdy  out  2*NUM_PAIR  beat ready; one-hot or zero.
- i_buf_afull  in  1  buffer almost full; blocks new grants only.
- o_iq_addr  out  ADDR_WIDTH  RE index within the burst.
- o_iq_data  out  ANT x 32  beat data.
- o_iq_vld  out  1  beat strobe.
- o_iq_last  out  1  final beat of a burst.
- o_info_0  out  64  latched header of the current burst.
- o_info_1  out  8  latched AGC of the current burst.
- o_grant_pair  out  log2(NUM_PAIR) min 1  pair being served.
- o_busy  out  1  state is not IDLE.
- o_err  out  1  sticky error; only driven with the optional feature.

Behaviour:
- Reset (asynchronous, i_rst_n=0): state IDLE, all outputs 0, RR pointer set to pair 0, beat counter 0, o_err 0.
- States:
  - IDLE -> ARB next cycle.
  - ARB: wait while i_buf_afull=1. Otherwise choose the first pair p at or after the RR pointer with i_src_req[2p]=1. Latch p and the even source's info, then go to EVEN. If no pair requests, stay in ARB.
  - EVEN: o_src_rdy[2p]=1. A beat is i_src_vld[2p] & rdy. Beat count RE_NUM-1 -> WAIT_ODD.
  - WAIT_ODD: wait for i_src_req[2p+1]. On req, latch the odd source's info and go to ODD. No other pair may be granted here.
  - ODD: same beat rules as EVEN on source 2p+1. Final beat -> GAP; RR pointer set to p+1 mod NUM_PAIR.
  - GAP: count GAP_CYC cycles, then go to ARB. With GAP_CYC=0, go to ARB on the next cycle.
- Output timing:
  - Registered, latency 1: o_iq_vld/o_iq_data/o_iq_addr appear one cycle after the accepted beat.
  - o_iq_addr = beat counter, 0..RE_NUM-1, reset to 0 at each burst start.
  - o_iq_last coincides with addr RE_NUM-1.
- o_info_0/1 update on the grant cycle and hold until the next grant.
- Source vld low mid-burst: no output beat, counter holds, rdy stays high.
- i_buf_afull rising mid-burst: ignored; the burst completes.
- i_src_req dropping after grant: ignored; the burst is committed.
- Reset asserted mid-burst: immediate abort, outputs to 0; the downstream buffer is reset by the same domain.
- Counter width is ADDR_WIDTH. RE_NUM <= 2^ADDR_WIDTH is a checked elaboration assertion.

Optional Feature:
- Macro ANT_BUF_SCHED_TIMEOUT_EN.
- Defined: a WAIT_ODD cycle counter runs. On reaching TIMEOUT, set o_err=1 (sticky until reset) and enter ODD_FILL. ODD_FILL emits RE_NUM zero-data beats, one per cycle, with normal addr/last and o_info held from the even burst; it then goes to GAP and advances RR. This keeps the buffer's even/odd alignment.
- Undefined: WAIT_ODD waits indefinitely and o_err is tied to 0.

Decomposition:
- Shared package ant_buf_pkg holds:
  - state enum sched_state_t {IDLE, ARB, EVEN, WAIT_ODD, ODD, ODD_FILL, GAP};
  - RE_NUM_DEFAULT = 1584;
  - IQ_WIDTH = 32.
- One sub-module: ant_buf_rr_arb, a combinational round-robin pick over NUM_PAIR requests with a pointer input, returning index and found.

Test Plan:
- Single pair, req[0] then req[1], vld always 1 -> 1584 beats with addr 0..1583, last at 1583, then 1584 odd beats; o_info switches at the odd grant; latency 1.
- Pairs 0 and 1 requesting continuously -> grant order 0,1,0,1; GAP_CYC=4 idle cycles between the odd last and the next even addr 0.
- Even source vld toggling 1010 -> output beats only on vld cycles, addr contiguous, total 1584.
- i_src_req[2] high while waiting on pair 0's odd source -> no grant to pair 1 until pair 0's odd burst ends.
- i_buf_afull=1 in ARB holds grant; afull asserted at beat 100 does not stall; reset at beat 500 -> all outputs 0 the same cycle.
- With macro, odd req withheld 4096 cycles -> o_err=1, 1584 zero-data beats, last at 1583.
